// File: rtl/purse_pkg.sv
// purse_pkg: shared definitions for the purse controller.
//   MONEY_W / LEVEL_W : balance and purse-level widths
//   state_t, S_*      : request-service FSM encoding
//   army_cost()       : spawn price by army index 0..7
//   upg_cost()        : upgrade price by current level 0..7
//   max_money()       : balance cap by level 0..7
package purse_pkg;

    localparam int MONEY_W = 15;
    localparam int LEVEL_W = 3;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CHECK = 2'd1;
    localparam state_t S_RESP  = 2'd2;

    function automatic logic [MONEY_W-1:0] army_cost(input logic [2:0] t);
        case (t)
            3'd0:    return 15'd75;
            3'd1:    return 15'd150;
            3'd2:    return 15'd240;
            3'd3:    return 15'd350;
            3'd4:    return 15'd750;
            3'd5:    return 15'd1500;
            3'd6:    return 15'd2000;
            default: return 15'd2400;
        endcase
    endfunction

    function automatic logic [MONEY_W-1:0] upg_cost(input logic [LEVEL_W-1:0] l);
        case (l)
            3'd0:    return 15'd100;
            3'd1:    return 15'd200;
            3'd2:    return 15'd400;
            3'd3:    return 15'd600;
            3'd4:    return 15'd1000;
            3'd5:    return 15'd2000;
            3'd6:    return 15'd4000;
            default: return 15'd8000;
        endcase
    endfunction

    function automatic logic [MONEY_W-1:0] max_money(input logic [LEVEL_W-1:0] l);
        case (l)
            3'd0:    return 15'd100;
            3'd1:    return 15'd300;
            3'd2:    return 15'd500;
            3'd3:    return 15'd1000;
            3'd4:    return 15'd2000;
            3'd5:    return 15'd4000;
            3'd6:    return 15'd6000;
            default: return 15'd10000;
        endcase
    endfunction

endpackage

// File: rtl/purse_income_timer.sv
// purse_income_timer: free-running income tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (counter -> 0)
//   en    : count enable; counter holds while low
//   tick  : high for the cycle in which the counter sits at TICK_CYCLES-1
module purse_income_timer #(
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the money update lands in the same cycle as the count.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/purse_controller.sv
// purse_controller: game purse - periodic income, army purchases and
// purse upgrades, served one request at a time by an IDLE/CHECK/RESP FSM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   en                    : game running; gates income, sampling and cheat
//   buy_req, buy_type     : spawn request (held until answered), army index
//   upg_req               : purse upgrade request (held until answered)
//   cheat                 : fill-to-max pulse, live only with PURSE_CHEAT_EN
//   money, level          : current balance and purse level
//   buy_grant/buy_deny    : one-cycle spawn response
//   upg_grant/upg_deny    : one-cycle upgrade response
// Build option: define PURSE_CHEAT_EN to enable the cheat input.
module purse_controller
    import purse_pkg::*;
#(
    parameter int TICK_CYCLES = 10_000_000,
    parameter int BASE_INC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        buy_req,
    input  logic [2:0]  buy_type,
    input  logic        upg_req,
    input  logic        cheat,
    output logic [14:0] money,
    output logic [2:0]  level,
    output logic        buy_grant,
    output logic        buy_deny,
    output logic        upg_grant,
    output logic        upg_deny
);

    state_t        state;
    logic          skip;          // blocks sampling in the cycle after RESP
    logic          rr_upg_first;  // 0: buy wins a tie, 1: upgrade wins
    logic          kind_upg;
    logic [14:0]   cost_q;
    logic          force_deny_q;  // upgrade requested at top level
    logic          grant_q;
    logic          tick;

    logic          can_sample;
    logic          pick_upg;
    logic          commit;
    logic [2:0]    level_d;
    logic [15:0]   inc;
    logic [15:0]   chk_money;
    logic [15:0]   money_sum;
    logic [15:0]   cap_d;
    logic [15:0]   money_nxt;

    purse_income_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign can_sample = (state == S_IDLE) && en && !skip && (buy_req || upg_req);
    assign pick_upg   = upg_req && (!buy_req || rr_upg_first);
    assign commit     = (state == S_RESP) && grant_q;

    always_comb begin
        inc   = 16'(BASE_INC) * (16'(level) + 16'd1);
        // Balance the CHECK decision sees: includes a same-cycle tick.
        chk_money = {1'b0, money};
        if (tick) begin
            chk_money = {1'b0, money} + inc;
            if (chk_money > {1'b0, max_money(level)})
                chk_money = {1'b0, max_money(level)};
        end

        level_d = level;
        if (commit && kind_upg)
            level_d = level + 3'd1;

        // CHECK guaranteed money >= cost, and nothing but reset can lower
        // money before RESP, so the subtraction never wraps.
        money_sum = {1'b0, money};
        if (commit)
            money_sum = money_sum - {1'b0, cost_q};
        if (tick)
            money_sum = money_sum + inc;
        cap_d     = {1'b0, max_money(level_d)};
        money_nxt = (money_sum > cap_d) ? cap_d : money_sum;
`ifdef PURSE_CHEAT_EN
        // Applied last so it overrides the tick and follows any commit.
        if (en && cheat)
            money_nxt = cap_d;
`endif
    end

`ifndef PURSE_CHEAT_EN
    logic cheat_unused;
    assign cheat_unused = cheat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            skip         <= 1'b0;
            rr_upg_first <= 1'b0;
            kind_upg     <= 1'b0;
            cost_q       <= '0;
            force_deny_q <= 1'b0;
            grant_q      <= 1'b0;
            money        <= '0;
            level        <= '0;
        end else begin
            money <= money_nxt[14:0];
            level <= level_d;
            case (state)
                S_IDLE: begin
                    skip <= 1'b0;
                    if (can_sample) begin
                        state        <= S_CHECK;
                        kind_upg     <= pick_upg;
                        cost_q       <= pick_upg ? upg_cost(level) : army_cost(buy_type);
                        force_deny_q <= pick_upg && (level == 3'd7);
                    end
                end
                S_CHECK: begin
                    grant_q <= !force_deny_q && (chk_money >= {1'b0, cost_q});
                    state   <= S_RESP;
                end
                S_RESP: begin
                    state        <= S_IDLE;
                    skip         <= 1'b1;
                    rr_upg_first <= !kind_upg;  // last served loses the next tie
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign buy_grant = (state == S_RESP) && !kind_upg &&  grant_q;
    assign buy_deny  = (state == S_RESP) && !kind_upg && !grant_q;
    assign upg_grant = (state == S_RESP) &&  kind_upg &&  grant_q;
    assign upg_deny  = (state == S_RESP) &&  kind_upg && !grant_q;

endmodule

// File: tb/tb_purse_controller.sv
// tb_purse_controller: scoreboard bench for purse_controller with
// TICK_CYCLES=4, BASE_INC=2. Expected responses are queued when a request
// is raised and checked when a response pulse appears; the balance and level
// are checked one cycle later. Income phase is tracked from en-high edges
// so expected balances can be derived around ticks.
module tb_purse_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        buy_req = 1'b0;
    logic        upg_req = 1'b0;
    logic        cheat = 1'b0;
    logic [2:0]  buy_type = 3'd0;
    logic [14:0] money;
    logic [2:0]  level;
    logic        buy_grant, buy_deny, upg_grant, upg_deny;

    purse_controller #(.TICK_CYCLES(4), .BASE_INC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .buy_req   (buy_req),
        .buy_type  (buy_type),
        .upg_req   (upg_req),
        .cheat     (cheat),
        .money     (money),
        .level     (level),
        .buy_grant (buy_grant),
        .buy_deny  (buy_deny),
        .upg_grant (upg_grant),
        .upg_deny  (upg_deny)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit upg;
        bit grant;
        int cyc;
        int money;
        int level;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   en_cyc = 0;
    int   resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Mirrors the income counter phase: counter value == en_cyc % 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  en_cyc <= 0;
        else if (en) en_cyc <= en_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Response monitor / scoreboard.
    initial begin
        logic [3:0] r;
        exp_t       e;
        exp_t       last;
        bit         pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            r = {upg_grant, upg_deny, buy_grant, buy_deny};
            if (pend) begin
                chk("money_after", 32'(money), last.money);
                chk("level_after", 32'(level), last.level);
                pend = 1'b0;
            end
            if (r != 4'd0) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(r), 0);
                end else begin
                    e = sb.pop_front();
                    chk(e.upg ? "upg_resp" : "buy_resp", 32'(r),
                        e.upg ? (e.grant ? 8 : 4) : (e.grant ? 2 : 1));
                    chk("resp_cycle", cyc, e.cyc);
                    last = e;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (resp_cnt < target) chk("resp_timeout", resp_cnt, target);
    endtask

    // Raise one request, hold it through the cycle after the response
    // (so a double service would show up as an unexpected pulse), then drop.
    task automatic do_req(input bit upg, input logic [2:0] t, input bit g,
                          input int m, input int l);
        exp_t e;
        int   start;
        e.upg = upg; e.grant = g; e.cyc = cyc + 2; e.money = m; e.level = l;
        sb.push_back(e);
        start = resp_cnt;
        buy_type = t;
        if (upg) upg_req = 1'b1;
        else     buy_req = 1'b1;
        wait_resp(start + 1);
        repeat (2) @(negedge clk);
        buy_req = 1'b0;
        upg_req = 1'b0;
    endtask

    task automatic align(input int ph);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((en_cyc % 4) != ph && n < 16);
    endtask

    task automatic wait_en(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (en_cyc != target && n < 1000);
        chk("wait_en", en_cyc, target);
    endtask

    initial begin
        exp_t e;
        int   start;

        // Reset state.
        #12;
        chk("rst_money", 32'(money), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_pulses", 32'({upg_grant, upg_deny, buy_grant, buy_deny}), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 en = 1'b1;

        // 200 cycles of income at level 0: 50 ticks * 2 = exactly the cap.
        repeat (200) @(posedge clk);
        #1;
        chk("sat_money", 32'(money), 100);
        chk("sat_level", 32'(level), 0);

        // Type 1 costs 150 > 100: denied, balance untouched.
        do_req(1'b0, 3'd1, 1'b0, 100, 0);

        // Upgrade at exactly 100: granted, then +4 per tick toward 300.
        align(0);
        do_req(1'b1, 3'd0, 1'b1, 0, 1);
        chk("inc_lvl1", 32'(money), 4);
        repeat (400) @(posedge clk);
        #1;
        chk("cap_lvl1", 32'(money), 300);

        // Simultaneous buy + upgrade at 300: buy wins the tie (upgrade was
        // served last). One +4 tick lands between the two commits, so the
        // upgrade sees 229 and leaves 29.
        align(0);
        e.upg = 1'b0; e.grant = 1'b1; e.cyc = cyc + 2; e.money = 225; e.level = 1;
        sb.push_back(e);
        e.upg = 1'b1; e.grant = 1'b1; e.cyc = cyc + 6; e.money = 29;  e.level = 2;
        sb.push_back(e);
        start = resp_cnt;
        buy_type = 3'd0;
        buy_req = 1'b1;
        upg_req = 1'b1;
        wait_resp(start + 1);
        repeat (2) @(negedge clk);
        buy_req = 1'b0;
        wait_resp(start + 2);
        repeat (2) @(negedge clk);
        upg_req = 1'b0;

        // Level 2, +6 ticks: 29 -> 35 -> 41 by the next phase-0 cycle.
        align(0);
        cheat = 1'b1;
        @(posedge clk); #1 cheat = 1'b0;
`ifdef PURSE_CHEAT_EN
        chk("cheat_fill", 32'(money), 500);
`else
        chk("cheat_ignored", 32'(money), 41);
`endif
        chk("cheat_level", 32'(level), 2);

        // Tick coinciding with the buy commit: 98 - 75 + 2.
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        #2 chk("rst2_level", 32'(level), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 en = 1'b1;
        wait_en(197);
        chk("pre_money", 32'(money), 98);
        do_req(1'b0, 3'd0, 1'b1, 25, 0);

        // Reset in CHECK: outputs clear at once, no late response.
        upg_req = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_chk_money", 32'(money), 0);
        chk("rst_chk_level", 32'(level), 0);
        chk("rst_chk_pulses", 32'({upg_grant, upg_deny, buy_grant, buy_deny}), 0);
        upg_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
